// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared word type and FSM state encoding for the adder round-robin arbiter.
package adder_arb_pkg;
   localparam int WORD_W = 5;
   typedef logic [WORD_W-1:0] word_t;
   typedef enum logic {EMPTY, FULL} arb_state_t;
endpackage

// File: rtl/fiveBitFullAdder.sv
// fiveBitFullAdder: 5-bit ripple-carry adder, {co,s} = a + b + ci.
module fiveBitFullAdder
   import adder_arb_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              ci,
   output logic [WORD_W-1:0] s,
   output logic              co
);
   logic [WORD_W:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < WORD_W; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[WORD_W];
endmodule

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, first valid at or above ptr (mod NREQ) wins.
module rr_picker #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  id
);
   logic [IDW-1:0] j;
   // scan from the farthest offset down so the nearest valid requester is written last
   always_comb begin
      grant = '0;
      id    = '0;
      j     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = IDW'((int'(ptr) + k) % NREQ);
         if (req_valid[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            id       = j;
         end
      end
   end
endmodule

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one fiveBitFullAdder with a registered, ID-tagged response.
// Define ADDER_ARB_OVF_EN to add the registered two's-complement overflow output rsp_ovf.
module adder_rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [WORD_W*NREQ-1:0] req_a,
   input  logic [WORD_W*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]        req_ci,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [WORD_W-1:0]      rsp_s,
   output logic                   rsp_co
`ifdef ADDER_ARB_OVF_EN
   ,
   output logic                   rsp_ovf
`endif
);
   arb_state_t      state, state_nx;
   logic [IDW-1:0]  ptr, ptr_nx, win;
   logic [NREQ-1:0] grant;
   logic            accept, ci, co;
   word_t           a, b, s;
   rr_picker #(.NREQ(NREQ)) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .id        (win)
   );
   // a new result may enter when the register is free or is being drained this cycle
   assign accept    = rst_n & (|req_valid) & (state == EMPTY | rsp_ready);
   assign req_ready = accept ? grant : '0;
   assign a         = req_a[WORD_W*win +: WORD_W];
   assign b         = req_b[WORD_W*win +: WORD_W];
   assign ci        = req_ci[win];
   assign ptr_nx    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
   assign rsp_valid = (state == FULL);
   fiveBitFullAdder u_add (
      .a  (a),
      .b  (b),
      .ci (ci),
      .s  (s),
      .co (co)
   );
   always_comb begin
      state_nx = accept ? FULL : rsp_ready ? EMPTY : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         ptr    <= '0;
         rsp_id <= '0;
         rsp_s  <= '0;
         rsp_co <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            ptr    <= ptr_nx;
            rsp_id <= win;
            rsp_s  <= s;
            rsp_co <= co;
         end
      end
   end
`ifdef ADDER_ARB_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rsp_ovf <= 1'b0;
      else if (accept)
         rsp_ovf <= (a[WORD_W-1] == b[WORD_W-1]) & (s[WORD_W-1] != a[WORD_W-1]);
   end
`endif
endmodule
